rv32i_pipelined_core: RTL and testbench



---
 rtl/rv32i_pipelined_core.sv | 233 +++++++++++++++++++++++
 tb/tb_rv32i_pipelined_core.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rv32i_pipelined_core.sv
// rv32i_pipelined_core: 3-stage RV32I (IF | DE/EX | MEM/WB) with machine-mode CSRs and timer interrupt.
// Memories, register file and CSR file are unreset arrays, preloaded hierarchically.
module inst_mem #(parameter int WORDS = 1024) (
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [31:0]              data
);
  logic [31:0] mem [0:WORDS-1];
  assign data = mem[addr];
endmodule

module reg_file (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_mem [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'h0 : reg_mem[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'h0 : reg_mem[ra2];
  always_ff @(posedge clk)
    if (we && wa != 5'd0) reg_mem[wa] <= wd;
endmodule

module data_mem #(parameter int WORDS = 1024) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [31:0]              wd,
  output logic [31:0]              rd
);
  logic [31:0] data_mem [0:WORDS-1];
  assign rd = data_mem[idx];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) data_mem[idx][8*i +: 8] <= wd[8*i +: 8];
endmodule

module csr_reg (
  input  logic        clk,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        ms_we,
  input  logic [31:0] ms_val,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic        mtip,
  output logic [31:0] mstatus,
  output logic [31:0] mie,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);
  logic [31:0] csr_mem [0:4095];
  logic [31:0] mip;
  assign rdata   = csr_mem[raddr];
  assign mstatus = csr_mem[12'h300];
  assign mie     = csr_mem[12'h304];
  assign mtvec   = csr_mem[12'h305];
  assign mepc    = csr_mem[12'h341];
  assign mip     = we && waddr == 12'h344 ? wdata : csr_mem[12'h344];
  // later assignments win: trap/mret updates override the committing CSR write
  always_ff @(posedge clk) begin
    if (we) csr_mem[waddr] <= wdata;
    if (ms_we) csr_mem[12'h300] <= ms_val;
    if (trap) begin
      csr_mem[12'h341] <= trap_pc;
      csr_mem[12'h342] <= 32'h80000007;
    end
    csr_mem[12'h344] <= {mip[31:8], mtip, mip[6:0]};
  end
endmodule

module rv32i_pipelined_core #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst,
  input logic timer_interrupt
);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, SYSTEM = 7'b1110011;
  logic [31:0] pc, instr_f, d_pc, d_instr;
  logic        d_valid;
  logic [4:0]  m_rd;
  logic        m_we, m_load, m_store, m_csr_we;
  logic [2:0]  m_f3;
  logic [11:0] m_csr_addr;
  logic [31:0] m_res, m_addr, m_sdata, m_csr_wdata;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2, sh;
  logic [2:0]  f3;
  logic [11:0] csr_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] r1, r2, a, b, bo, alu, res, addr, target, w_res;
  logic [31:0] csr_rdata, mstatus_raw, mie_raw, mtvec_raw, mepc_raw;
  logic [31:0] mst, mie_v, mtvec_v, mepc_v, csr_old, csr_src, csr_new, ms_val;
  logic [31:0] dm_rdata, ld_raw, ld, st_data;
  logic [3:0]  st_be;
  logic        take, is_csr, csr_we, is_mret, irq, redirect, wr;

  // CSR view for stage 2, including the write about to commit in stage 3
  function automatic logic [31:0] csr_fw(input logic [11:0] ca, input logic [31:0] v);
    return m_csr_we && m_csr_addr == ca ? m_csr_wdata : v;
  endfunction

  inst_mem #(.WORDS(IMEM_WORDS)) inst_mem_i (.addr(pc[IW+1:2]), .data(instr_f));

  assign op       = d_instr[6:0];
  assign rd       = d_instr[11:7];
  assign f3       = d_instr[14:12];
  assign rs1      = d_instr[19:15];
  assign rs2      = d_instr[24:20];
  assign csr_addr = d_instr[31:20];
  assign imm_i    = {{20{d_instr[31]}}, d_instr[31:20]};
  assign imm_s    = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
  assign imm_b    = {{20{d_instr[31]}}, d_instr[7], d_instr[30:25], d_instr[11:8], 1'b0};
  assign imm_u    = {d_instr[31:12], 12'b0};
  assign imm_j    = {{12{d_instr[31]}}, d_instr[19:12], d_instr[20], d_instr[30:21], 1'b0};

  reg_file reg_file_i (
    .clk(clk), .ra1(rs1), .ra2(rs2), .we(m_we), .wa(m_rd), .wd(w_res), .rd1(r1), .rd2(r2)
  );

  assign a  = m_we && m_rd == rs1 ? w_res : r1;
  assign b  = m_we && m_rd == rs2 ? w_res : r2;
  assign bo = op == OP ? b : imm_i;
  assign sh = bo[4:0];

  always_comb
    case (f3)
      3'd0:    alu = op == OP && d_instr[30] ? a - bo : a + bo;
      3'd1:    alu = a << sh;
      3'd2:    alu = {31'b0, $signed(a) < $signed(bo)};
      3'd3:    alu = {31'b0, a < bo};
      3'd4:    alu = a ^ bo;
      3'd5:    alu = d_instr[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    alu = a | bo;
      default: alu = a & bo;
    endcase

  assign take = op == BRANCH && (f3[2:1] == 2'b00 ? (a == b) ^ f3[0] :
                                 f3[2:1] == 2'b10 ? ($signed(a) < $signed(b)) ^ f3[0] :
                                 f3[2:1] == 2'b11 ? (a < b) ^ f3[0] : 1'b0);

  csr_reg csr_reg_i (
    .clk(clk), .raddr(csr_addr), .rdata(csr_rdata),
    .we(m_csr_we), .waddr(m_csr_addr), .wdata(m_csr_wdata),
    .ms_we(irq || is_mret), .ms_val(ms_val), .trap(irq), .trap_pc(d_pc), .mtip(timer_interrupt),
    .mstatus(mstatus_raw), .mie(mie_raw), .mtvec(mtvec_raw), .mepc(mepc_raw)
  );

  assign mst     = csr_fw(12'h300, mstatus_raw);
  assign mie_v   = csr_fw(12'h304, mie_raw);
  assign mtvec_v = csr_fw(12'h305, mtvec_raw);
  assign mepc_v  = csr_fw(12'h341, mepc_raw);
  assign csr_old = csr_fw(csr_addr, csr_rdata);
  assign is_csr  = op == SYSTEM && f3[1:0] != 2'b00;
  assign csr_src = f3[2] ? {27'b0, rs1} : a;
  assign csr_new = f3[1:0] == 2'b01 ? csr_src : f3[1:0] == 2'b10 ? csr_old | csr_src : csr_old & ~csr_src;
  assign csr_we  = is_csr && (f3[1:0] == 2'b01 || rs1 != 5'd0);
  assign is_mret = d_instr == 32'h30200073;
  assign irq     = timer_interrupt && d_valid && mst[3] && mie_v[7];
  assign ms_val  = irq ? {mst[31:8], mst[3], mst[6:4], 1'b0, mst[2:0]}
                       : {mst[31:8], 1'b1, mst[6:4], mst[7], mst[2:0]};

  assign redirect = irq || is_mret || op == JAL || op == JALR || take;
  assign target   = irq ? {mtvec_v[31:2], 2'b00} : is_mret ? mepc_v : op == JAL ? d_pc + imm_j :
                    op == JALR ? (a + imm_i) & ~32'd1 : d_pc + imm_b;
  assign res      = op == LUI ? imm_u : op == AUIPC ? d_pc + imm_u :
                    op == JAL || op == JALR ? d_pc + 32'd4 : is_csr ? csr_old : alu;
  assign wr       = !irq && rd != 5'd0 && (op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP} || is_csr);
  assign addr     = a + (op == STORE ? imm_s : imm_i);

  data_mem #(.WORDS(DMEM_WORDS)) data_mem_i (
    .clk(clk), .we(m_store), .be(st_be), .idx(m_addr[DW+1:2]), .wd(st_data), .rd(dm_rdata)
  );

  assign ld_raw  = dm_rdata >> {m_addr[1:0], 3'b000};
  assign ld      = m_f3[1:0] == 2'b00 ? {{24{~m_f3[2] & ld_raw[7]}}, ld_raw[7:0]} :
                   m_f3[1:0] == 2'b01 ? {{16{~m_f3[2] & ld_raw[15]}}, ld_raw[15:0]} : ld_raw;
  assign w_res   = m_load ? ld : m_res;
  assign st_be   = (m_f3[1:0] == 2'b00 ? 4'b0001 : m_f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << m_addr[1:0];
  assign st_data = m_sdata << {m_addr[1:0], 3'b000};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc          <= RESET_PC;
      d_pc        <= RESET_PC;
      d_instr     <= NOP;
      d_valid     <= 1'b0;
      m_rd        <= 5'd0;
      m_we        <= 1'b0;
      m_load      <= 1'b0;
      m_store     <= 1'b0;
      m_csr_we    <= 1'b0;
      m_f3        <= 3'd0;
      m_csr_addr  <= 12'd0;
      m_res       <= 32'd0;
      m_addr      <= 32'd0;
      m_sdata     <= 32'd0;
      m_csr_wdata <= 32'd0;
    end else begin
      pc          <= redirect ? target : pc + 32'd4;
      d_pc        <= pc;
      d_instr     <= redirect ? NOP : instr_f;
      d_valid     <= !redirect;
      m_rd        <= rd;
      m_we        <= wr;
      m_load      <= op == LOAD;
      m_store     <= op == STORE && !irq;
      m_csr_we    <= csr_we && !irq;
      m_f3        <= f3;
      m_csr_addr  <= csr_addr;
      m_res       <= res;
      m_addr      <= addr;
      m_sdata     <= b;
      m_csr_wdata <= csr_new;
    end
endmodule

// File: tb/tb_rv32i_pipelined_core.sv
// tb_rv32i_pipelined_core: program-driven bench; register writebacks are scored against an ordered queue.
module tb_rv32i_pipelined_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timer_interrupt = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] sb_q [$];
  logic [36:0] ent;

  rv32i_pipelined_core dut (.clk(clk), .rst(rst), .timer_interrupt(timer_interrupt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] csr(input logic [11:0] ca, input logic [4:0] rs1, input logic [2:0] f3);
    return enc_i(ca, rs1, f3, 5'd0, 7'h73);
  endfunction

  task automatic load_program();
    logic [31:0] prog [0:25];
    prog = '{addi(1, 0, 5), addi(2, 1, 7), addi(0, 0, 9),
             enc_s(4, 2, 0, 3'd2), enc_i(4, 0, 3'd2, 3, 7'h03), enc_r(7'h00, 3, 3, 3'd0, 4),
             enc_b(8, 0, 0, 3'd0), addi(5, 0, 1), enc_j(8, 7), addi(5, 0, 2),
             addi(6, 0, 12'h100), csr(12'h305, 6, 3'd1), addi(8, 0, 12'h080), csr(12'h304, 8, 3'd2),
             addi(9, 0, 8), csr(12'h300, 9, 3'd2),
             addi(10, 0, 1), addi(11, 0, 2), addi(12, 0, 3), addi(13, 0, 4),
             enc_r(7'h20, 2, 1, 3'd0, 15), enc_i(12'h401, 15, 3'd5, 16, 7'h13),
             enc_s(9, 15, 0, 3'd0), enc_i(9, 0, 3'd0, 18, 7'h03), enc_i(8, 0, 3'd5, 19, 7'h03),
             enc_j(0, 0)};
    for (int i = 0; i < 1024; i++) dut.inst_mem_i.mem[i] = 32'h00000013;
    for (int i = 0; i < 26; i++) dut.inst_mem_i.mem[i] = prog[i];
    dut.inst_mem_i.mem[64] = addi(14, 0, 12'h055);
    dut.inst_mem_i.mem[65] = csr(12'h304, 8, 3'd3);
    dut.inst_mem_i.mem[66] = 32'h30200073;
    for (int i = 0; i < 32; i++) dut.reg_file_i.reg_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dut.data_mem_i.data_mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) dut.csr_reg_i.csr_mem[i] = 32'h0;
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] v);
    sb_q.push_back({rd, v});
  endtask

  // The handler write (x14) lands before the cancelled ADDI x10 re-executes
  task automatic push_run(input bit with_irq);
    exp_wr(1, 5); exp_wr(2, 12); exp_wr(3, 12); exp_wr(4, 24); exp_wr(7, 32'h24);
    exp_wr(6, 32'h100); exp_wr(8, 32'h80); exp_wr(9, 8);
    if (with_irq) exp_wr(14, 32'h55);
    exp_wr(10, 1); exp_wr(11, 2); exp_wr(12, 3); exp_wr(13, 4);
    exp_wr(15, 32'hFFFFFFF9); exp_wr(16, 32'hFFFFFFFC); exp_wr(18, 32'hFFFFFFF9); exp_wr(19, 32'h0000F900);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb_q.size(), 0);
  endtask

  always @(negedge clk)
    if (rst && dut.reg_file_i.we && dut.reg_file_i.wa != 5'd0) begin
      if (sb_q.size() == 0) check("wr_unexpected", {27'b0, dut.reg_file_i.wa}, 32'h0);
      else begin
        ent = sb_q.pop_front();
        check($sformatf("wr_rd_x%0d", ent[36:32]), {27'b0, dut.reg_file_i.wa}, {27'b0, ent[36:32]});
        check($sformatf("wr_val_x%0d", ent[36:32]), dut.reg_file_i.wd, ent[31:0]);
      end
    end

  initial begin
    int n;
    load_program();
    push_run(1'b1);
    repeat (2) @(negedge clk);
    check("rst_pc", dut.pc, 32'h0);
    check("rst_d_instr", dut.d_instr, 32'h00000013);
    check("rst_m_we", {31'b0, dut.m_we}, 32'h0);
    timer_interrupt = 1'b1;
    rst = 1'b1;
    n = 0;
    while (dut.pc !== 32'h100 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("trap_pc", dut.pc, 32'h100);
    check("trap_mepc", dut.csr_reg_i.csr_mem[12'h341], 32'h40);
    check("trap_mcause", dut.csr_reg_i.csr_mem[12'h342], 32'h80000007);
    check("trap_mstatus", dut.csr_reg_i.csr_mem[12'h300], 32'h80);
    drain("drain_run1");
    repeat (10) @(negedge clk);
    check("x0_zero", dut.reg_file_i.reg_mem[0], 32'h0);
    check("x5_skipped", dut.reg_file_i.reg_mem[5], 32'h0);
    check("dmem1_sw", dut.data_mem_i.data_mem[1], 32'd12);
    check("dmem2_sb", dut.data_mem_i.data_mem[2], 32'h0000F900);
    check("mret_mstatus", dut.csr_reg_i.csr_mem[12'h300], 32'h88);
    check("mtvec", dut.csr_reg_i.csr_mem[12'h305], 32'h100);
    check("mie_cleared", dut.csr_reg_i.csr_mem[12'h304], 32'h0);
    check("loop_pc", dut.pc & 32'hFFFFFFF8, 32'h60);
    timer_interrupt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_pc", dut.pc, 32'h0);
    check("async_rst_x4", dut.reg_file_i.reg_mem[4], 32'd24);
    check("async_rst_dmem", dut.data_mem_i.data_mem[1], 32'd12);
    push_run(1'b0);
    repeat (2) @(negedge clk);
    check("held_pc", dut.pc, 32'h0);
    rst = 1'b1;
    drain("drain_run2");
    repeat (10) @(negedge clk);
    check("run2_mepc_kept", dut.csr_reg_i.csr_mem[12'h341], 32'h40);
    check("run2_x19", dut.reg_file_i.reg_mem[19], 32'h0000F900);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
